// File: rtl/core_inst_buffer.sv
// core_inst_buffer
// Two-wide instruction queue between fetch F2 and decode. Fetch packets of
// 0-2 instructions are compacted into a circular buffer; the oldest 0-2
// entries are presented to decode combinationally.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   flush_i        drop all buffered entries and this cycle's packet/pop
//   valid_i        per-slot valid of the fetch packet (slot k at {pc[31:3],k,2'b00})
//   inst_i         packet instructions, [0] = lower address
//   pc_i           packet PC, bits [31:3] used
//   attached_i     packet side info, copied into every written entry
//   stall_o        buffer cannot take a full two-wide packet
//   valid_o        thermometer valid of the oldest entries (00/01/11)
//   inst_o         oldest two instructions, [0] = oldest
//   pc_o           full PCs of the presented instructions
//   attached_o     side info of the presented instructions
//   pop_i          decode consumption (00/01/11)
//   count_o        current occupancy, 0..DEPTH
module core_inst_buffer #(
  parameter int ATTACHED_INFO_WIDTH = 32,
  parameter int DEPTH               = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic [1:0]                          valid_i,
  input  logic [1:0][31:0]                    inst_i,
  input  logic [31:0]                         pc_i,
  input  logic [ATTACHED_INFO_WIDTH-1:0]      attached_i,
  output logic                                stall_o,
  output logic [1:0]                          valid_o,
  output logic [1:0][31:0]                    inst_o,
  output logic [1:0][31:0]                    pc_o,
  output logic [1:0][ATTACHED_INFO_WIDTH-1:0] attached_o,
  input  logic [1:0]                          pop_i,
  output logic [$clog2(DEPTH):0]              count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("core_inst_buffer: DEPTH must be a power of two and at least 4");
  end

  // Entry storage; no reset needed, contents only matter once counted.
  logic [31:0]                    inst_mem [DEPTH];
  logic [29:0]                    pc_mem   [DEPTH];
  logic [ATTACHED_INFO_WIDTH-1:0] att_mem  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [PW-1:0] wr_ptr1, rd_ptr1;
  logic          push_ok;
  logic [CW-1:0] n_push, n_pop;
  logic          pop0, pop1;

  // Write-port selection after compaction.
  logic          w0_en, w1_en;
  logic [31:0]   w0_inst;
  logic [29:0]   w0_pc, w1_pc;

  logic [2:0]    unused_pc;
  assign unused_pc = pc_i[2:0];

  assign wr_ptr1 = wr_ptr + PW'(1);
  assign rd_ptr1 = rd_ptr + PW'(1);

  // Threshold from the registered count only, so pop_i never reaches stall_o.
  assign stall_o = (count >= CW'(DEPTH - 1));
  assign push_ok = !stall_o && !flush_i;

  always_comb begin
    w0_en   = 1'b0;
    w1_en   = 1'b0;
    w0_inst = inst_i[0];
    w0_pc   = {pc_i[31:3], 1'b0};
    w1_pc   = {pc_i[31:3], 1'b1};
    n_push  = '0;
    if (push_ok) begin
      n_push = CW'(valid_i[0]) + CW'(valid_i[1]);
      w0_en  = |valid_i;
      w1_en  = &valid_i;
      // A lone slot-1 instruction lands at wr_ptr, keeping its own PC.
      if (valid_i == 2'b10) begin
        w0_inst = inst_i[1];
        w0_pc   = {pc_i[31:3], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w0_en) begin
      inst_mem[wr_ptr] <= w0_inst;
      pc_mem[wr_ptr]   <= w0_pc;
      att_mem[wr_ptr]  <= attached_i;
    end
    if (w1_en) begin
      inst_mem[wr_ptr1] <= inst_i[1];
      pc_mem[wr_ptr1]   <= w1_pc;
      att_mem[wr_ptr1]  <= attached_i;
    end
  end

  assign valid_o[0] = (count >= CW'(1));
  assign valid_o[1] = (count >= CW'(2));

  assign inst_o[0]     = inst_mem[rd_ptr];
  assign inst_o[1]     = inst_mem[rd_ptr1];
  assign pc_o[0]       = {pc_mem[rd_ptr], 2'b00};
  assign pc_o[1]       = {pc_mem[rd_ptr1], 2'b00};
  assign attached_o[0] = att_mem[rd_ptr];
  assign attached_o[1] = att_mem[rd_ptr1];

  // Slot 1 may only be consumed together with slot 0.
  assign pop0  = pop_i[0] && valid_o[0] && !flush_i;
  assign pop1  = pop_i[1] && pop0 && valid_o[1];
  assign n_pop = CW'(pop0) + CW'(pop1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PW-1:0];
      rd_ptr <= rd_ptr + n_pop[PW-1:0];
      count  <= count + n_push - n_pop;
    end
  end

  assign count_o = count;

  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) begin
      assert (!(stall_o && (valid_i != 2'b00)))
        else $error("core_inst_buffer: packet presented while stalled");
    end
    if (rst_n) begin
      assert (count <= CW'(DEPTH))
        else $error("core_inst_buffer: occupancy exceeds DEPTH");
    end
  end

endmodule

// File: tb/tb_core_inst_buffer.sv
module tb_core_inst_buffer;

  localparam int AW    = 32;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush_i;
  logic [1:0]          valid_i;
  logic [1:0][31:0]    inst_i;
  logic [31:0]         pc_i;
  logic [AW-1:0]       attached_i;
  logic                stall_o;
  logic [1:0]          valid_o;
  logic [1:0][31:0]    inst_o;
  logic [1:0][31:0]    pc_o;
  logic [1:0][AW-1:0]  attached_o;
  logic [1:0]          pop_i;
  logic [3:0]          count_o;

  int errors = 0;
  int checks = 0;

  core_inst_buffer #(.ATTACHED_INFO_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i),
    .inst_i(inst_i), .pc_i(pc_i), .attached_i(attached_i), .stall_o(stall_o),
    .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o), .attached_o(attached_o),
    .pop_i(pop_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    valid_i = 2'b00;
    pop_i   = 2'b00;
    flush_i = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i1, input logic [31:0] i0,
                       input logic [31:0] pc, input logic [1:0] pop);
    valid_i    = v;
    inst_i[0]  = i0;
    inst_i[1]  = i1;
    pc_i       = pc;
    attached_i = pc ^ 32'h5A5A_0000;
    pop_i      = pop;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", valid_o); end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
  endtask

  task automatic test_pair();
    drive(2'b11, 32'hBBBB_0001, 32'hAAAA_0001, 32'h1C00_0000, 2'b00);
    tick();
    checks++; if (valid_o !== 2'b11) begin errors++; $display("FAIL pair_valid got=%b exp=11", valid_o); end
    checks++; if (inst_o[0] !== 32'hAAAA_0001) begin errors++; $display("FAIL pair_inst0 got=%h exp=aaaa0001", inst_o[0]); end
    checks++; if (inst_o[1] !== 32'hBBBB_0001) begin errors++; $display("FAIL pair_inst1 got=%h exp=bbbb0001", inst_o[1]); end
    checks++; if (pc_o[0] !== 32'h1C00_0000) begin errors++; $display("FAIL pair_pc0 got=%h exp=1c000000", pc_o[0]); end
    checks++; if (pc_o[1] !== 32'h1C00_0004) begin errors++; $display("FAIL pair_pc1 got=%h exp=1c000004", pc_o[1]); end
    checks++; if (attached_o[0] !== 32'h465A_0000) begin errors++; $display("FAIL pair_att0 got=%h exp=465a0000", attached_o[0]); end
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL pair_count got=%0d exp=2", count_o); end
  endtask

  task automatic test_compact();
    drive(2'b10, 32'hCCCC_0001, 32'hDEAD_DEAD, 32'h1C00_0008, 2'b00);
    tick();
    checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL compact_count got=%0d exp=3", count_o); end
    pop_i = 2'b11;
    tick();
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL compact_count_pop got=%0d exp=1", count_o); end
    checks++; if (valid_o !== 2'b01) begin errors++; $display("FAIL compact_valid got=%b exp=01", valid_o); end
    checks++; if (inst_o[0] !== 32'hCCCC_0001) begin errors++; $display("FAIL compact_inst got=%h exp=cccc0001", inst_o[0]); end
    checks++; if (pc_o[0] !== 32'h1C00_000C) begin errors++; $display("FAIL compact_pc got=%h exp=1c00000c", pc_o[0]); end
    pop_i = 2'b11;  // only one valid: the [1] request must be ignored
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL compact_drain got=%0d exp=0", count_o); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_cnt;
    do_flush();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'hF000_0001 + 32'(2*k), 32'hF000_0000 + 32'(2*k), 32'h3000_0000 + 32'(8*k), 2'b00);
      tick();
      exp_cnt = 4'(2*k + 2);
      checks++; if (count_o !== exp_cnt) begin errors++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count_o, exp_cnt); end
      checks++; if (stall_o !== (k == 3)) begin errors++; $display("FAIL fill_stall k=%0d got=%b exp=%b", k, stall_o, (k == 3)); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (inst_o[0] !== 32'hF000_0000 + 32'(2*k) || inst_o[1] !== 32'hF000_0001 + 32'(2*k))
        begin errors++; $display("FAIL fill_order k=%0d got=%h,%h exp=%h,%h", k, inst_o[0], inst_o[1],
                                 32'hF000_0000 + 32'(2*k), 32'hF000_0001 + 32'(2*k)); end
      pop_i = 2'b11;
      tick();
      exp_cnt = 4'(6 - 2*k);
      checks++; if (count_o !== exp_cnt) begin errors++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, count_o, exp_cnt); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL drain_stall k=%0d got=%b exp=0", k, stall_o); end
    end
  endtask

  task automatic test_back_to_back();
    do_flush();
    drive(2'b11, 32'hE000_0001, 32'hE000_0000, 32'h4000_0000, 2'b00);
    tick();
    drive(2'b01, 32'h0, 32'hE000_0002, 32'h4000_0008, 2'b00);
    tick();
    checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL b2b_pre_count got=%0d exp=3", count_o); end
    drive(2'b11, 32'hE000_0004, 32'hE000_0003, 32'h4000_0010, 2'b01);
    tick();
    checks++; if (count_o !== 4'd4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", count_o); end
    checks++; if (inst_o[0] !== 32'hE000_0001 || inst_o[1] !== 32'hE000_0002)
      begin errors++; $display("FAIL b2b_order got=%h,%h exp=e0000001,e0000002", inst_o[0], inst_o[1]); end
    checks++; if (pc_o[1] !== 32'h4000_0008) begin errors++; $display("FAIL b2b_pc1 got=%h exp=40000008", pc_o[1]); end
  endtask

  task automatic test_wrap();
    logic [1:0] vpat [20] = '{2'd3,2'd1,2'd2,2'd3,2'd3,2'd1,2'd2,2'd3,2'd0,2'd3,
                              2'd2,2'd1,2'd3,2'd3,2'd1,2'd2,2'd3,2'd3,2'd1,2'd2};
    logic [1:0] ppat [20] = '{2'd0,2'd1,2'd0,2'd3,2'd1,2'd0,2'd3,2'd1,2'd3,2'd1,
                              2'd3,2'd0,2'd1,2'd3,2'd3,2'd1,2'd0,2'd3,2'd1,2'd3};
    logic [31:0] q_inst [$];
    logic [31:0] q_pc [$];
    logic [31:0] tag;
    logic [31:0] pc;
    logic [1:0]  v;
    logic [1:0]  expv;
    int          np;
    tag = 32'h7700_0000;
    pc  = 32'h0800_0000;
    do_flush();
    for (int c = 0; c < 20; c++) begin
      v = ((DEPTH - q_inst.size()) < 2) ? 2'b00 : vpat[c];
      np = 0;
      if (ppat[c][0] && q_inst.size() >= 1) np = (ppat[c][1] && q_inst.size() >= 2) ? 2 : 1;
      drive(v, tag + 1, tag, pc, ppat[c]);
      for (int k = 0; k < np; k++) begin
        void'(q_inst.pop_front());
        void'(q_pc.pop_front());
      end
      if (v[0]) begin q_inst.push_back(tag);     q_pc.push_back(pc);          end
      if (v[1]) begin q_inst.push_back(tag + 1); q_pc.push_back(pc + 32'd4);  end
      tick();
      tag = tag + 32'h10;
      pc  = pc + 32'h8;
      expv = (q_inst.size() >= 2) ? 2'b11 : (q_inst.size() == 1) ? 2'b01 : 2'b00;
      checks++; if (count_o !== 4'(q_inst.size())) begin errors++; $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, count_o, q_inst.size()); end
      checks++; if (valid_o !== expv) begin errors++; $display("FAIL wrap_valid c=%0d got=%b exp=%b", c, valid_o, expv); end
      if (q_inst.size() >= 1) begin
        checks++; if (inst_o[0] !== q_inst[0] || pc_o[0] !== q_pc[0])
          begin errors++; $display("FAIL wrap_head c=%0d got=%h@%h exp=%h@%h", c, inst_o[0], pc_o[0], q_inst[0], q_pc[0]); end
      end
      if (q_inst.size() >= 2) begin
        checks++; if (inst_o[1] !== q_inst[1] || pc_o[1] !== q_pc[1])
          begin errors++; $display("FAIL wrap_next c=%0d got=%h@%h exp=%h@%h", c, inst_o[1], pc_o[1], q_inst[1], q_pc[1]); end
      end
    end
  endtask

  task automatic test_flush();
    do_flush();
    drive(2'b11, 32'h9000_0001, 32'h9000_0000, 32'h5000_0000, 2'b00); tick();
    drive(2'b11, 32'h9000_0003, 32'h9000_0002, 32'h5000_0008, 2'b00); tick();
    drive(2'b01, 32'h0,         32'h9000_0004, 32'h5000_0010, 2'b00); tick();
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL flush_pre_count got=%0d exp=5", count_o); end
    drive(2'b11, 32'hBAD0_0001, 32'hBAD0_0000, 32'h5000_0018, 2'b11);
    flush_i = 1'b1;
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    checks++; if (valid_o !== 2'b00) begin errors++; $display("FAIL flush_valid got=%b exp=00", valid_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
    drive(2'b01, 32'h0, 32'h1234_5678, 32'h2000_0040, 2'b00);
    tick();
    checks++; if (valid_o !== 2'b01 || count_o !== 4'd1)
      begin errors++; $display("FAIL flush_after got=%b/%0d exp=01/1", valid_o, count_o); end
    checks++; if (inst_o[0] !== 32'h1234_5678 || pc_o[0] !== 32'h2000_0040)
      begin errors++; $display("FAIL flush_after_head got=%h@%h exp=12345678@20000040", inst_o[0], pc_o[0]); end
  endtask

  initial begin
    rst_n      = 1'b0;
    flush_i    = 1'b0;
    valid_i    = 2'b00;
    pop_i      = 2'b00;
    inst_i     = '0;
    pc_i       = '0;
    attached_i = '0;
    test_reset();
    test_pair();
    test_compact();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
